seven_segment_capture: RTL and testbench



---
 rtl/seven_segment_capture_pkg.sv | 50 +++++
 rtl/seven_segment_capture_decode.sv | 15 +
 rtl/seven_segment_capture.sv | 138 +++++++++++++
 tb/tb_seven_segment_capture.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seven_segment_capture_pkg.sv
// Shared definitions for the seven-segment bus reader: segment patterns,
// the pattern decoder and the per-digit capture FSM states.
package seg7_pkg;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Active-low patterns, seg[6]=a .. seg[0]=g
  localparam logic [6:0] SEG_0 = 7'b0000001;
  localparam logic [6:0] SEG_1 = 7'b1001111;
  localparam logic [6:0] SEG_2 = 7'b0010010;
  localparam logic [6:0] SEG_3 = 7'b0000110;
  localparam logic [6:0] SEG_4 = 7'b1001100;
  localparam logic [6:0] SEG_5 = 7'b0100100;
  localparam logic [6:0] SEG_6 = 7'b0100000;
  localparam logic [6:0] SEG_7 = 7'b0001111;
  localparam logic [6:0] SEG_8 = 7'b0000000;
  localparam logic [6:0] SEG_9 = 7'b0001100;
  localparam logic [6:0] SEG_A = 7'b0001000;
  localparam logic [6:0] SEG_B = 7'b1100000;
  localparam logic [6:0] SEG_C = 7'b0110001;
  localparam logic [6:0] SEG_D = 7'b1000010;
  localparam logic [6:0] SEG_E = 7'b0110000;
  localparam logic [6:0] SEG_F = 7'b0111000;

  localparam logic [15:0][6:0] SEG_TABLE = {
    SEG_F, SEG_E, SEG_D, SEG_C, SEG_B, SEG_A, SEG_9, SEG_8,
    SEG_7, SEG_6, SEG_5, SEG_4, SEG_3, SEG_2, SEG_1, SEG_0
  };

  typedef enum logic [1:0] {
    WAIT,
    SETTLE,
    HELD
  } cap_state_t;

  // Returns {err, blank, nibble}; unknown patterns report err with nibble 0.
  function automatic logic [5:0] seg_decode(input logic [6:0] seg);
    logic [5:0] r;
    r = {1'b1, 1'b0, 4'h0};
    if (seg == SEG_BLANK) begin
      r = {1'b0, 1'b1, 4'h0};
    end else begin
      for (int unsigned i = 0; i < 16; i++) begin
        if (seg == SEG_TABLE[i]) r = {2'b00, 4'(i)};
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/seven_segment_capture_decode.sv
// Combinational segment-pattern decoder for the capture block.
module seven_segment_decode
  import seg7_pkg::*;
(
  input  logic [6:0] seg,
  output logic [3:0] nibble,
  output logic       blank,
  output logic       err
);

  always_comb begin
    {err, blank, nibble} = seg_decode(seg);
  end

endmodule

// File: rtl/seven_segment_capture.sv
// Reader for a multiplexed seven-segment bus: filters each digit for
// stability, decodes it and publishes a full frame with a one-cycle strobe.
module seven_segment_capture
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [6:0]              seg,
  input  logic [NUM_DIGITS-1:0]   dig_sel,
  output logic                    frame_valid,
  output logic [4*NUM_DIGITS-1:0] hex_frame,
  output logic [NUM_DIGITS-1:0]   blank_frame,
  output logic [NUM_DIGITS-1:0]   err_frame
);

  localparam int CW = (STABLE_CYCLES > 2) ? $clog2(STABLE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_PRE  = CW'(STABLE_CYCLES - 2);

  logic [6:0]              seg_q;
  logic [NUM_DIGITS-1:0]   sel_q;
  cap_state_t              state, state_d;
  logic [CW-1:0]           cnt, cnt_d;
  logic                    capture;
  logic                    same;
  logic                    onehot;

  logic [NUM_DIGITS-1:0]   mask;
  logic                    mask_full;
  logic [4*NUM_DIGITS-1:0] sh_hex;
  logic [NUM_DIGITS-1:0]   sh_blank;
  logic [NUM_DIGITS-1:0]   sh_err;

  logic [3:0]              dec_nibble;
  logic                    dec_blank;
  logic                    dec_err;

  seven_segment_decode u_decode (
    .seg    (seg_q),
    .nibble (dec_nibble),
    .blank  (dec_blank),
    .err    (dec_err)
  );

  assign same      = (seg == seg_q) && (dig_sel == sel_q);
  assign onehot    = $onehot(dig_sel);
  assign mask_full = &mask;

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    capture = 1'b0;
    unique case (state)
      WAIT: begin
        cnt_d = '0;
        if (onehot) state_d = SETTLE;
      end
      SETTLE: begin
        if (!same) begin
          cnt_d   = '0;
          state_d = onehot ? SETTLE : WAIT;
        end else begin
          cnt_d = (cnt == CNT_LAST) ? cnt : cnt + CW'(1);
          // held pair reaches STABLE_CYCLES consecutive cycles on this edge
          if (cnt == CNT_PRE) begin
            capture = 1'b1;
            state_d = HELD;
          end
        end
      end
      HELD: begin
        if (!same) begin
          cnt_d   = '0;
          state_d = onehot ? SETTLE : WAIT;
        end else begin
          cnt_d = (cnt == CNT_LAST) ? cnt : cnt + CW'(1);
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = WAIT;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_q <= '0;
      sel_q <= '0;
      state <= WAIT;
      cnt   <= '0;
    end else begin
      seg_q <= seg;
      sel_q <= dig_sel;
      state <= state_d;
      cnt   <= cnt_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mask     <= '0;
      sh_hex   <= '0;
      sh_blank <= '0;
      sh_err   <= '0;
    end else begin
      // a capture landing on the publish edge survives the mask clear
      mask <= (mask_full ? '0 : mask) | (capture ? sel_q : '0);
      for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
        if (capture && sel_q[i]) begin
          sh_hex[4*i +: 4] <= dec_nibble;
          sh_blank[i]      <= dec_blank;
          sh_err[i]        <= dec_err;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_valid <= 1'b0;
      hex_frame   <= '0;
      blank_frame <= '0;
      err_frame   <= '0;
    end else begin
      frame_valid <= mask_full;
      if (mask_full) begin
        hex_frame   <= sh_hex;
        blank_frame <= sh_blank;
        err_frame   <= sh_err;
      end
    end
  end

endmodule

// File: tb/tb_seven_segment_capture.sv
// Directed bench for seven_segment_capture with four digits, STABLE_CYCLES=4.
module tb_seven_segment_capture;

  logic        clk;
  logic        rst_n;
  logic [6:0]  seg;
  logic [3:0]  dig_sel;
  logic        frame_valid;
  logic [15:0] hex_frame;
  logic [3:0]  blank_frame;
  logic [3:0]  err_frame;

  int n_tests;
  int n_fail;

  logic [6:0] pat [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0001100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

  seven_segment_capture #(
    .NUM_DIGITS    (4),
    .STABLE_CYCLES (4)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .seg         (seg),
    .dig_sel     (dig_sel),
    .frame_valid (frame_valid),
    .hex_frame   (hex_frame),
    .blank_frame (blank_frame),
    .err_frame   (err_frame)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Frame monitor: counts strobes, records published values, flags
  // strobes longer than one cycle and output changes outside a strobe.
  int          fv_cnt = 0;
  int          fv_run = 0;
  int          viol   = 0;
  logic [15:0] last_hex;
  logic [3:0]  last_blank;
  logic [3:0]  last_err;
  logic [15:0] prev_hex;
  logic [3:0]  prev_blank;
  logic [3:0]  prev_err;

  always @(negedge clk) begin
    if (!rst_n) begin
      fv_run = 0;
    end else if (frame_valid) begin
      fv_cnt++;
      fv_run++;
      if (fv_run > 1) viol++;
      last_hex   = hex_frame;
      last_blank = blank_frame;
      last_err   = err_frame;
    end else begin
      fv_run = 0;
      if (hex_frame !== prev_hex || blank_frame !== prev_blank || err_frame !== prev_err)
        viol++;
    end
    prev_hex   = hex_frame;
    prev_blank = blank_frame;
    prev_err   = err_frame;
  end

  task automatic do_reset();
    rst_n = 1'b0;
    dig_sel = '0;
    seg = 7'b1111111;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic hold(input int d, input logic [6:0] s, input int n);
    dig_sel = 4'b0001 << d;
    seg = s;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    dig_sel = '0;
    seg = 7'b1111111;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic sweep(input int v0, input int v1, input int v2, input int v3, input int n);
    hold(0, pat[v0], n);
    hold(1, pat[v1], n);
    hold(2, pat[v2], n);
    hold(3, pat[v3], n);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    dig_sel = '0;
    seg = 7'b1111111;
    repeat (3) @(posedge clk);
    #1;
    n_tests++;
    if (frame_valid !== 1'b0) begin n_fail++; $display("FAIL reset_fv: got %b want 0", frame_valid); end
    n_tests++;
    if (hex_frame !== 16'h0000) begin n_fail++; $display("FAIL reset_hex: got %h want 0000", hex_frame); end
    n_tests++;
    if (blank_frame !== 4'b0000) begin n_fail++; $display("FAIL reset_blank: got %b want 0000", blank_frame); end
    n_tests++;
    if (err_frame !== 4'b0000) begin n_fail++; $display("FAIL reset_err: got %b want 0000", err_frame); end
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    int n0;
    do_reset();
    n0 = fv_cnt;
    sweep(1, 2, 10, 15, 6);
    idle(3);
    n_tests++;
    if (fv_cnt - n0 !== 1) begin n_fail++; $display("FAIL basic_count: got %0d want 1", fv_cnt - n0); end
    n_tests++;
    if (last_hex !== 16'hFA21) begin n_fail++; $display("FAIL basic_hex: got %h want fa21", last_hex); end
    n_tests++;
    if (last_blank !== 4'b0000 || last_err !== 4'b0000) begin
      n_fail++; $display("FAIL basic_flags: got blank %b err %b want 0000 0000", last_blank, last_err);
    end
    n_tests++;
    if (hex_frame !== 16'hFA21) begin n_fail++; $display("FAIL basic_held: got %h want fa21", hex_frame); end
  endtask

  task automatic test_short_hold();
    int n0;
    do_reset();
    n0 = fv_cnt;
    hold(0, pat[1], 6);
    hold(1, pat[2], 6);
    hold(2, pat[10], 3);
    hold(3, pat[15], 6);
    n_tests++;
    if (fv_cnt - n0 !== 0) begin n_fail++; $display("FAIL short_first_pass: got %0d frames want 0", fv_cnt - n0); end
    n_tests++;
    if (hex_frame !== 16'h0000) begin n_fail++; $display("FAIL short_hex_untouched: got %h want 0000", hex_frame); end
    hold(0, pat[1], 6);
    hold(1, pat[2], 6);
    hold(2, pat[10], 6);
    n_tests++;
    if (fv_cnt - n0 !== 1) begin n_fail++; $display("FAIL short_after_d2: got %0d frames want 1", fv_cnt - n0); end
    n_tests++;
    if (last_hex !== 16'hFA21) begin n_fail++; $display("FAIL short_hex: got %h want fa21", last_hex); end
    hold(3, pat[15], 6);
    idle(3);
    n_tests++;
    if (fv_cnt - n0 !== 1) begin n_fail++; $display("FAIL short_residue: got %0d frames want 1", fv_cnt - n0); end
  endtask

  task automatic test_blank_err();
    int n0;
    do_reset();
    n0 = fv_cnt;
    hold(0, pat[5], 6);
    hold(1, 7'b1111111, 6);
    hold(2, pat[7], 6);
    hold(3, 7'b1111110, 6);
    idle(3);
    n_tests++;
    if (fv_cnt - n0 !== 1) begin n_fail++; $display("FAIL be_count: got %0d want 1", fv_cnt - n0); end
    n_tests++;
    if (last_hex !== 16'h0705) begin n_fail++; $display("FAIL be_hex: got %h want 0705", last_hex); end
    n_tests++;
    if (last_blank !== 4'b0010) begin n_fail++; $display("FAIL be_blank: got %b want 0010", last_blank); end
    n_tests++;
    if (last_err !== 4'b1000) begin n_fail++; $display("FAIL be_err: got %b want 1000", last_err); end
  endtask

  task automatic test_multihot();
    int n0;
    do_reset();
    n0 = fv_cnt;
    dig_sel = 4'b0011;
    seg = pat[3];
    repeat (10) @(posedge clk);
    #1;
    hold(2, pat[6], 6);
    hold(3, pat[9], 6);
    idle(3);
    n_tests++;
    if (fv_cnt - n0 !== 0) begin n_fail++; $display("FAIL multihot_no_frame: got %0d want 0", fv_cnt - n0); end
    hold(0, pat[12], 6);
    hold(1, pat[13], 6);
    idle(3);
    n_tests++;
    if (fv_cnt - n0 !== 1) begin n_fail++; $display("FAIL multihot_count: got %0d want 1", fv_cnt - n0); end
    n_tests++;
    if (last_hex !== 16'h96DC) begin n_fail++; $display("FAIL multihot_hex: got %h want 96dc", last_hex); end
  endtask

  task automatic test_reset_mid();
    int n0;
    do_reset();
    sweep(4, 4, 4, 4, 6);
    idle(2);
    hold(0, pat[11], 6);
    hold(1, pat[11], 6);
    hold(2, pat[11], 6);
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (hex_frame !== 16'h0000 || blank_frame !== 4'b0000 || err_frame !== 4'b0000 || frame_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset_outputs: got fv %b hex %h blank %b err %b want all 0",
               frame_valid, hex_frame, blank_frame, err_frame);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    n0 = fv_cnt;
    sweep(14, 0, 8, 3, 6);
    idle(3);
    n_tests++;
    if (fv_cnt - n0 !== 1) begin n_fail++; $display("FAIL mid_reset_count: got %0d want 1", fv_cnt - n0); end
    n_tests++;
    if (last_hex !== 16'h380E) begin n_fail++; $display("FAIL mid_reset_hex: got %h want 380e", last_hex); end
  endtask

  task automatic test_long_hold();
    int n0;
    do_reset();
    n0 = fv_cnt;
    hold(0, pat[8], 20);
    hold(1, pat[3], 6);
    hold(2, pat[4], 6);
    hold(3, pat[5], 6);
    idle(3);
    n_tests++;
    if (fv_cnt - n0 !== 1) begin n_fail++; $display("FAIL long_count: got %0d want 1", fv_cnt - n0); end
    n_tests++;
    if (last_hex !== 16'h5438) begin n_fail++; $display("FAIL long_hex: got %h want 5438", last_hex); end
  endtask

  task automatic test_decode_table();
    int n0;
    logic [15:0] exp_hex;
    do_reset();
    for (int k = 0; k < 4; k++) begin
      n0 = fv_cnt;
      sweep(4*k, 4*k+1, 4*k+2, 4*k+3, 5);
      idle(3);
      exp_hex = {4'(4*k+3), 4'(4*k+2), 4'(4*k+1), 4'(4*k)};
      n_tests++;
      if (fv_cnt - n0 !== 1 || last_hex !== exp_hex || last_blank !== 4'b0000 || last_err !== 4'b0000) begin
        n_fail++;
        $display("FAIL table_frame%0d: got n %0d hex %h blank %b err %b want n 1 hex %h blank 0000 err 0000",
                 k, fv_cnt - n0, last_hex, last_blank, last_err, exp_hex);
      end
    end
  endtask

  task automatic test_back_to_back();
    int n0;
    do_reset();
    n0 = fv_cnt;
    sweep(1, 2, 3, 4, 4);
    sweep(9, 8, 7, 6, 4);
    idle(3);
    n_tests++;
    if (fv_cnt - n0 !== 2) begin n_fail++; $display("FAIL b2b_count: got %0d want 2", fv_cnt - n0); end
    n_tests++;
    if (last_hex !== 16'h6789) begin n_fail++; $display("FAIL b2b_hex: got %h want 6789", last_hex); end
  endtask

  task automatic test_output_stability();
    n_tests++;
    if (viol !== 0) begin n_fail++; $display("FAIL output_stability: got %0d violations want 0", viol); end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_n   = 1'b0;
    dig_sel = '0;
    seg     = 7'b1111111;
    test_reset();
    test_basic();
    test_short_hold();
    test_blank_err();
    test_multihot();
    test_reset_mid();
    test_long_hold();
    test_decode_table();
    test_back_to_back();
    test_output_stability();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
